// File: rtl/ps2_move_decoder_pkg.sv
// Scancodes, direction encodings, decoder states and the key lookup shared by the
// PS/2 move decoder and its bench-facing users.
package ps2_move_decoder_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       is_dir;
    logic       is_enter;
    logic [1:0] dir;
  } key_t;

  // Arrows only exist in the extended table; WASD and Enter only in the plain one.
  function automatic key_t decode_key(input logic [7:0] code, input logic ext);
    key_t k;
    k = '0;
    if (ext) begin
      case (code)
        SC_UP:    begin k.is_dir = 1'b1; k.dir = DIR_UP;    end
        SC_DOWN:  begin k.is_dir = 1'b1; k.dir = DIR_DOWN;  end
        SC_LEFT:  begin k.is_dir = 1'b1; k.dir = DIR_LEFT;  end
        SC_RIGHT: begin k.is_dir = 1'b1; k.dir = DIR_RIGHT; end
        default:  ;
      endcase
    end else begin
      case (code)
        SC_W:     begin k.is_dir = 1'b1; k.dir = DIR_UP;    end
        SC_S:     begin k.is_dir = 1'b1; k.dir = DIR_DOWN;  end
        SC_A:     begin k.is_dir = 1'b1; k.dir = DIR_LEFT;  end
        SC_D:     begin k.is_dir = 1'b1; k.dir = DIR_RIGHT; end
        SC_ENTER: k.is_enter = 1'b1;
        default:  ;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_move_decoder_key_repeat_timer.sv
// Auto-repeat down-counter: expire pulses one cycle before the count would hit zero,
// so a reload of N yields pulses N cycles apart.
module key_repeat_timer #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic load_delay,
  input  logic load_period,
  input  logic enable,
  output logic expire
);

  localparam int MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXV + 1);

  logic [CW-1:0] cnt;

  // A fresh press must load even while the previous direction is idle.
  always_ff @(posedge CLOCK_50) begin
    if (reset)              cnt <= '0;
    else if (load_delay)    cnt <= CW'(REPEAT_DELAY);
    else if (!enable)       cnt <= '0;
    else if (load_period)   cnt <= CW'(REPEAT_PERIOD);
    else if (cnt != '0)     cnt <= cnt - CW'(1);
  end

  assign expire = enable && (cnt == CW'(1));

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 set-2 make/break decoder: held-key levels plus one-cycle move pulses with
// typematic suppression, auto-repeat of the active direction and prefix timeout.
module ps2_move_decoder
  import ps2_move_decoder_pkg::*;
#(
  parameter int REPEAT_DELAY   = 25_000_000,
  parameter int REPEAT_PERIOD  = 5_000_000,
  parameter int PREFIX_TIMEOUT = 2_500_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [3:0] key_held,
  output logic       enter_held,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [7:0] last_code
);

  localparam int TO_W = $clog2(PREFIX_TIMEOUT + 1);

  dec_state_t     state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic           dec_en, dec_brk, dec_ext, timeout;
  key_t           key;
  logic           act_vld;
  logic [1:0]     act_dir;
  logic           make_new, brk_act, rep_fire, expire;

  always_comb begin
    state_nxt = state;
    dec_en    = 1'b0;
    dec_brk   = 1'b0;
    dec_ext   = 1'b0;
    timeout   = (state != ST_IDLE) && (to_cnt == TO_W'(PREFIX_TIMEOUT - 1));
    if (received_data_en) begin
      if (received_data == SC_E0) begin
        state_nxt = ST_EXT;
      end else begin
        case (state)
          ST_IDLE:
            if (received_data == SC_F0) state_nxt = ST_BRK;
            else                        dec_en    = 1'b1;
          ST_EXT:
            if (received_data == SC_F0) state_nxt = ST_EXT_BRK;
            else begin
              dec_en    = 1'b1;
              dec_ext   = 1'b1;
              state_nxt = ST_IDLE;
            end
          ST_BRK: begin
            dec_en    = 1'b1;
            dec_brk   = 1'b1;
            state_nxt = ST_IDLE;
          end
          ST_EXT_BRK: begin
            dec_en    = 1'b1;
            dec_brk   = 1'b1;
            dec_ext   = 1'b1;
            state_nxt = ST_IDLE;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end else if (timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  assign key      = decode_key(received_data, dec_ext);
  assign make_new = dec_en && !dec_brk && key.is_dir && !key_held[key.dir];
  assign brk_act  = dec_en && dec_brk && key.is_dir && act_vld && (act_dir == key.dir);
  // A new press owns the pulse slot; releasing the active key kills a pending repeat.
  assign rep_fire = expire && !make_new && !brk_act;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= ST_IDLE;
      to_cnt     <= '0;
      key_held   <= '0;
      enter_held <= 1'b0;
      move_valid <= 1'b0;
      move_dir   <= DIR_UP;
      last_code  <= 8'h00;
      act_vld    <= 1'b0;
      act_dir    <= DIR_UP;
    end else begin
      state      <= state_nxt;
      to_cnt     <= (received_data_en || state_nxt == ST_IDLE) ? '0 : to_cnt + TO_W'(1);
      move_valid <= make_new || rep_fire;
      if (received_data_en && received_data != SC_E0 && received_data != SC_F0)
        last_code <= received_data;
      if (dec_en && key.is_dir)   key_held[key.dir] <= !dec_brk;
      if (dec_en && key.is_enter) enter_held        <= !dec_brk;
      if (make_new) begin
        move_dir <= key.dir;
        act_dir  <= key.dir;
        act_vld  <= 1'b1;
      end else if (rep_fire) begin
        move_dir <= act_dir;
      end
      if (brk_act) act_vld <= 1'b0;
    end
  end

  key_repeat_timer #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_timer (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .load_delay  (make_new),
    .load_period (rep_fire),
    .enable      (act_vld),
    .expire      (expire)
  );

endmodule
